bundler: RTL and testbench
==========================

Name: bundler

Overview:
- Hyperdimensional-computing bundler: per-dimension majority vote across NUM_HVS binary hypervectors, producing one DIMENSIONS-bit bundled hypervector.
- Serial-parallel datapath: PAR_BITS dimensions evaluated per clock, so one bundle takes DIMENSIONS/PAR_BITS cycles.
- Sits after the binding/encoding stage of the seizure-detection pipeline and feeds the associative/classification stage.

Parameters:
- DIMENSIONS, 6: hypervector width in bits.
- NUM_HVS, 6: number of input hypervectors bundled; legal range >= 2; odd or even.
- PAR_BITS, 2: dimensions processed per cycle; DIMENSIONS % PAR_BITS == 0 required (elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  start strobe; samples hv_array when idle.
- hv_array  input  unpacked [NUM_HVS-1:0] of [DIMENSIONS-1:0]  input hypervectors.
- out  output  1  done pulse, high one cycle when hv_out is updated.
- hv_out  output  DIMENSIONS  bundled result, held until next completion.

Behaviour:
- Reset (nrst=0, async): state IDLE, out=0, hv_out=0, capture register=0, chunk counter=0, partial result=0.
- States: IDLE, BUSY.
- IDLE: on a rising edge with en=1, copy all of hv_array into the internal capture register, clear the counter, and go to BUSY. en=0 means stay in IDLE.
- BUSY: each edge evaluates chunk c, bits [c*PAR_BITS +: PAR_BITS], starting at c=0 (LSBs). The result is written into the partial-result register.
- BUSY counter: c increments by 1 per edge. The edge that evaluates the last chunk (c = DIMENSIONS/PAR_BITS - 1) loads the full result into hv_out, sets out=1 and returns to IDLE.
- out is registered. It is 1 for exactly the one cycle following the final chunk edge and 0 otherwise.
- Latency: en sampled at edge k; hv_out/out valid after edge k + DIMENSIONS/PAR_BITS. For defaults that is 3 cycles.
- Majority rule per bit i: cnt = number of j with hv_array[j][i]=1.
  - cnt > NUM_HVS/2 gives 1.
  - cnt < NUM_HVS/2 gives 0.
  - Tie (even NUM_HVS, cnt == NUM_HVS/2) gives hv_array[0][i] XOR hv_array[1][i], the standard extra tie-break vector.
  - Odd NUM_HVS never ties.
- Counter width: $clog2(NUM_HVS+1) bits; no overflow possible.
- en while BUSY is ignored. The capture register is not reloaded, and hv_array changes during BUSY have no effect.
- en in the same cycle out=1: the FSM is already IDLE, so a new capture is accepted. Back-to-back bundles are allowed with no idle gap.
- hv_out is unchanged except on completion. Partial chunks never appear on hv_out.
- Reset mid-BUSY aborts the operation: out=0, hv_out=0, no completion pulse afterwards.

Decomposition:
- Shared package hdc_pkg: default DIMENSIONS/NUM_HVS/PAR_BITS constants, and a function or constant for counter width $clog2(NUM_HVS+1).
- One natural sub-module: bundler_majority_bit. It is a combinational popcount of an NUM_HVS-bit column plus a tie-break input, giving a 1-bit majority. Instantiate it PAR_BITS times in a generate loop.
- FSM, counter, capture register and result register live in bundler.

Test Plan:
- Reset: nrst=0 for 10 cycles -> out=0, hv_out=000000. Release with en=0 -> stays 0.
- Even ties: en pulse with hv_array[0..5] = 001101, 000111, 001111, 100011, 100011, 111011 -> after 3 cycles out pulses once, hv_out=001011.
- Ties plus sparse: 000010, 010000, 001000, 010100, 000100, 010000 -> hv_out=010000, out one-cycle pulse.
- Clear majorities: 111011, 011011, 001111, 010111, 110101, 111110 -> hv_out=111111. The previous 010000 is held until the completion edge.
- Busy/back-to-back:
  - Change hv_array and pulse en during BUSY -> ignored; result matches the first capture.
  - en asserted in the out cycle -> a second result arrives 3 cycles later.
- Reset mid-operation and odd config:
  - nrst low during BUSY -> no out pulse, hv_out=0.
  - NUM_HVS=5, DIMENSIONS=8, PAR_BITS=4 -> strict majority with no tie path, 2-cycle latency.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared HDC constants and types. Popcount width must hold NUM_HVS itself.
package hdc_pkg;

  localparam int DIMENSIONS_DEF = 6;
  localparam int NUM_HVS_DEF    = 6;
  localparam int PAR_BITS_DEF   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bundler_state_e;

  function automatic int popcnt_width(input int num_hvs);
    return $clog2(num_hvs + 1);
  endfunction

endpackage

// File: rtl/bundler_majority_bit.sv
// Combinational majority of one hypervector column; latency 0, no flow control.
// A tie (even NUM_HVS only) resolves to the caller-supplied tie-break bit.
module bundler_majority_bit
  import hdc_pkg::*;
#(
  parameter int NUM_HVS = NUM_HVS_DEF
) (
  input  logic [NUM_HVS-1:0] col,
  input  logic               tie_brk,
  output logic               maj
);

  localparam int              CNTW = popcnt_width(NUM_HVS);
  localparam logic [CNTW-1:0] HALF = CNTW'(NUM_HVS / 2);
  localparam bit              EVEN = (NUM_HVS % 2) == 0;

  logic [CNTW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int j = 0; j < NUM_HVS; j++) begin
      cnt = cnt + CNTW'(col[j]);
    end
  end

  // For odd NUM_HVS, cnt == HALF is a strict minority, not a tie.
  always_comb begin
    maj = 1'b0;
    if (cnt > HALF) begin
      maj = 1'b1;
    end else if (EVEN && (cnt == HALF)) begin
      maj = tie_brk;
    end
  end

endmodule

// File: rtl/bundler.sv
// Serial-parallel majority bundler, PAR_BITS dimensions per cycle; DIMENSIONS/PAR_BITS cycles from en to out.
// No backpressure: en is only honoured while idle, and is ignored while a bundle is in flight.
module bundler
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEF,
  parameter int NUM_HVS    = NUM_HVS_DEF,
  parameter int PAR_BITS   = PAR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_array [NUM_HVS-1:0],
  output logic                  out,
  output logic [DIMENSIONS-1:0] hv_out
);

  localparam int            NCHUNKS = DIMENSIONS / PAR_BITS;
  localparam int            CW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NCHUNKS - 1);

  if ((DIMENSIONS % PAR_BITS) != 0) begin : g_bad_par_bits
    $error("bundler: DIMENSIONS must be a multiple of PAR_BITS");
  end
  if (NUM_HVS < 2) begin : g_bad_num_hvs
    $error("bundler: NUM_HVS must be at least 2");
  end

  bundler_state_e        state_q, state_d;
  logic [DIMENSIONS-1:0] cap_q [NUM_HVS-1:0];
  logic [DIMENSIONS-1:0] cap_d [NUM_HVS-1:0];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIMENSIONS-1:0] part_q, part_d;
  logic [DIMENSIONS-1:0] hv_out_q, hv_out_d;
  logic                  out_q, out_d;

  int                    chunk_base;
  logic [NUM_HVS-1:0]    col [PAR_BITS];
  logic [PAR_BITS-1:0]   tie;
  logic [PAR_BITS-1:0]   maj;
  logic [DIMENSIONS-1:0] part_full;

  assign chunk_base = int'(cnt_q) * PAR_BITS;

  // Transpose the current chunk of the capture register into per-dimension columns.
  always_comb begin
    for (int p = 0; p < PAR_BITS; p++) begin
      col[p] = '0;
      for (int j = 0; j < NUM_HVS; j++) begin
        col[p][j] = cap_q[j][chunk_base + p];
      end
      tie[p] = col[p][0] ^ col[p][1];
    end
  end

  for (genvar p = 0; p < PAR_BITS; p++) begin : g_maj
    bundler_majority_bit #(
      .NUM_HVS (NUM_HVS)
    ) u_maj (
      .col     (col[p]),
      .tie_brk (tie[p]),
      .maj     (maj[p])
    );
  end

  always_comb begin
    part_full                           = part_q;
    part_full[chunk_base +: PAR_BITS]   = maj;
  end

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    part_d   = part_q;
    hv_out_d = hv_out_q;
    out_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          cap_d   = hv_array;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        part_d = part_full;
        if (cnt_q == LAST) begin
          hv_out_d = part_full;
          out_d    = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      for (int j = 0; j < NUM_HVS; j++) begin
        cap_q[j] <= '0;
      end
      cnt_q    <= '0;
      part_q   <= '0;
      hv_out_q <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      hv_out_q <= hv_out_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign hv_out = hv_out_q;

endmodule

// File: tb/tb_bundler.sv
// Directed bench for bundler: default 6x6/2 config plus an odd 5-vector, 8-bit, 4-wide config.
module tb_bundler;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en_a, en_b;
  logic [5:0] hv_a [5:0];
  logic [7:0] hv_b [4:0];
  logic       out_a, out_b;
  logic [5:0] hvo_a;
  logic [7:0] hvo_b;

  int n_checks = 0;
  int n_pass   = 0;
  int seen_out;

  always #5 clk = ~clk;

  bundler #(
    .DIMENSIONS (6),
    .NUM_HVS    (6),
    .PAR_BITS   (2)
  ) u_dut_a (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en_a),
    .hv_array (hv_a),
    .out      (out_a),
    .hv_out   (hvo_a)
  );

  bundler #(
    .DIMENSIONS (8),
    .NUM_HVS    (5),
    .PAR_BITS   (4)
  ) u_dut_b (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en_b),
    .hv_array (hv_b),
    .out      (out_b),
    .hv_out   (hvo_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [5:0] v0, input logic [5:0] v1, input logic [5:0] v2,
                        input logic [5:0] v3, input logic [5:0] v4, input logic [5:0] v5);
    hv_a[0] = v0; hv_a[1] = v1; hv_a[2] = v2;
    hv_a[3] = v3; hv_a[4] = v4; hv_a[5] = v5;
  endtask

  task automatic load_b(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                        input logic [7:0] v3, input logic [7:0] v4);
    hv_b[0] = v0; hv_b[1] = v1; hv_b[2] = v2; hv_b[3] = v3; hv_b[4] = v4;
  endtask

  // en sampled on the first edge, result visible after the third edge beyond it.
  task automatic run_a(input string tag, input logic [5:0] exp, input logic [5:0] held);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    check_eq({tag, "_out_c1"}, 32'(out_a), 32'(0));
    check_eq({tag, "_held_c1"}, 32'(hvo_a), 32'(held));
    step();
    check_eq({tag, "_out_c2"}, 32'(out_a), 32'(0));
    check_eq({tag, "_held_c2"}, 32'(hvo_a), 32'(held));
    step();
    check_eq({tag, "_out_done"}, 32'(out_a), 32'(1));
    check_eq({tag, "_hv"}, 32'(hvo_a), 32'(exp));
    step();
    check_eq({tag, "_out_drop"}, 32'(out_a), 32'(0));
    check_eq({tag, "_hv_hold"}, 32'(hvo_a), 32'(exp));
  endtask

  initial begin
    nrst = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    load_a('0, '0, '0, '0, '0, '0);
    load_b('0, '0, '0, '0, '0);
    repeat (10) step();
    check_eq("rst_out_a", 32'(out_a), 32'(0));
    check_eq("rst_hv_a", 32'(hvo_a), 32'(0));
    check_eq("rst_out_b", 32'(out_b), 32'(0));
    check_eq("rst_hv_b", 32'(hvo_b), 32'(0));
    nrst = 1'b1;
    repeat (4) step();
    check_eq("idle_out_a", 32'(out_a), 32'(0));
    check_eq("idle_hv_a", 32'(hvo_a), 32'(0));

    load_a(6'b001101, 6'b000111, 6'b001111, 6'b100011, 6'b100011, 6'b111011);
    run_a("ties", 6'b001011, 6'b000000);

    load_a(6'b000010, 6'b010000, 6'b001000, 6'b010100, 6'b000100, 6'b010000);
    run_a("sparse", 6'b010000, 6'b001011);

    load_a(6'b111011, 6'b011011, 6'b001111, 6'b010111, 6'b110101, 6'b111110);
    run_a("clear", 6'b111111, 6'b010000);

    // Inputs and en change mid-bundle; then a new en lands in the out cycle.
    load_a(6'b001101, 6'b000111, 6'b001111, 6'b100011, 6'b100011, 6'b111011);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    load_a(6'b111011, 6'b011011, 6'b001111, 6'b010111, 6'b110101, 6'b111110);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    check_eq("busy_out_c2", 32'(out_a), 32'(0));
    step();
    check_eq("busy_out_done", 32'(out_a), 32'(1));
    check_eq("busy_hv", 32'(hvo_a), 32'(6'b001011));
    load_a(6'b000010, 6'b010000, 6'b001000, 6'b010100, 6'b000100, 6'b010000);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    check_eq("b2b_out_drop", 32'(out_a), 32'(0));
    step();
    step();
    check_eq("b2b_out_c2", 32'(out_a), 32'(0));
    check_eq("b2b_held", 32'(hvo_a), 32'(6'b001011));
    step();
    check_eq("b2b_out_done", 32'(out_a), 32'(1));
    check_eq("b2b_hv", 32'(hvo_a), 32'(6'b010000));
    step();

    // Reset lands after the first chunk has been evaluated.
    load_a(6'b111011, 6'b011011, 6'b001111, 6'b010111, 6'b110101, 6'b111110);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    nrst = 1'b0;
    #1;
    check_eq("midrst_out", 32'(out_a), 32'(0));
    check_eq("midrst_hv", 32'(hvo_a), 32'(0));
    step();
    nrst = 1'b1;
    seen_out = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_a) seen_out++;
    end
    check_eq("midrst_no_pulse", 32'(seen_out), 32'(0));
    check_eq("midrst_hv_after", 32'(hvo_a), 32'(0));

    // Odd config: cnt == NUM_HVS/2 is a minority even where hv[0]^hv[1] is 1.
    load_b(8'b1100_1010, 8'b1010_0110, 8'b0110_0011, 8'b1001_1001, 8'b0000_1111);
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    step();
    check_eq("odd_out_c1", 32'(out_b), 32'(0));
    check_eq("odd_held_c1", 32'(hvo_b), 32'(0));
    step();
    check_eq("odd_out_done", 32'(out_b), 32'(1));
    check_eq("odd_hv", 32'(hvo_b), 32'(8'h8B));
    step();
    check_eq("odd_out_drop", 32'(out_b), 32'(0));

    load_b(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00);
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    step();
    check_eq("odd2_held", 32'(hvo_b), 32'(8'h8B));
    step();
    check_eq("odd2_out_done", 32'(out_b), 32'(1));
    check_eq("odd2_hv", 32'(hvo_b), 32'(8'h00));
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
